// File: rtl/mem_map_pkg.sv
// Shared address map and router state type for the data-side interconnect.
package mem_map_pkg;

    localparam int DEF_N_REGIONS = 4;
    localparam int MAP_AW        = 64;

    // Region i matches when (addr & REGION_MASK[i]) == REGION_BASE[i].
    // 0: data RAM 0x000-0x0FF, 1: peripherals 0x100-0x11F,
    // 2: timer 0x200-0x20F, 3: UART 0x300-0x30F.
    localparam logic [DEF_N_REGIONS-1:0][MAP_AW-1:0] REGION_BASE = {
        64'h0000_0000_0000_0300,
        64'h0000_0000_0000_0200,
        64'h0000_0000_0000_0100,
        64'h0000_0000_0000_0000
    };

    localparam logic [DEF_N_REGIONS-1:0][MAP_AW-1:0] REGION_MASK = {
        64'hFFFF_FFFF_FFFF_FFF0,
        64'hFFFF_FFFF_FFFF_FFF0,
        64'hFFFF_FFFF_FFFF_FFE0,
        64'hFFFF_FFFF_FFFF_FF00
    };

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } rtr_state_t;

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder: finds the lowest-index region matching addr
// and strips the region base to form the target-local offset.
module addr_decode
    import mem_map_pkg::*;
#(
    parameter int AW        = 64,
    parameter int N_REGIONS = DEF_N_REGIONS,
    parameter int IW        = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [AW-1:0] offset
);

    // Scan from the highest index downwards so the lowest matching index wins.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i][AW-1:0]) == REGION_BASE[i][AW-1:0]) begin
                hit    = 1'b1;
                idx    = IW'(i);
                offset = addr & ~REGION_MASK[i][AW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_bus_router.sv
// Data-side bus router: one outstanding core request routed to a mapped
// target with per-target ack, plus unmapped-address and timeout errors.
module mem_bus_router
    import mem_map_pkg::*;
#(
    parameter int DW        = 64,
    parameter int AW        = 64,
    parameter int N_REGIONS = DEF_N_REGIONS,
    parameter int TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [AW-1:0]           req_addr,
    input  logic [DW-1:0]           req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_err,
    output logic [N_REGIONS-1:0]    s_sel,
    output logic                    s_wen,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    input  logic [N_REGIONS*DW-1:0] s_rdata,
    input  logic [N_REGIONS-1:0]    s_ack
);

    localparam int IW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    rtr_state_t             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [N_REGIONS-1:0]   s_sel_q, s_sel_d;
    logic                   s_wen_q, s_wen_d;
    logic [AW-1:0]          s_addr_q, s_addr_d;
    logic [DW-1:0]          s_wdata_q, s_wdata_d;

    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic [AW-1:0]          dec_offset;

    addr_decode #(
        .AW        (AW),
        .N_REGIONS (N_REGIONS),
        .IW        (IW)
    ) u_addr_decode (
        .addr   (req_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    // Next-state logic: accept/decode in IDLE, wait for ack or timeout in ACCESS, hold response in RESP.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        s_sel_d     = s_sel_q;
        s_wen_d     = s_wen_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_hit) begin
                        idx_d            = dec_idx;
                        s_sel_d          = '0;
                        s_sel_d[dec_idx] = 1'b1;
                        s_wen_d          = req_wen;
                        s_addr_d         = dec_offset;
                        s_wdata_d        = req_wdata;
                        cnt_d            = '0;
                        state_d          = ACCESS;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                if (s_ack[idx_q]) begin
                    rsp_rdata_d = s_wen_q ? '0 : s_rdata[idx_q*DW +: DW];
                    rsp_err_d   = 1'b0;
                    s_sel_d     = '0;
                    s_wen_d     = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    s_sel_d     = '0;
                    s_wen_d     = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            s_sel_q     <= '0;
            s_wen_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            s_sel_q     <= s_sel_d;
            s_wen_q     <= s_wen_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign s_sel     = s_sel_q;
    assign s_wen     = s_wen_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed testbench for mem_bus_router with a response scoreboard.
module tb_mem_bus_router;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int NR = 4;
   localparam int TO = 16;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_wen;
   logic [AW-1:0]    req_addr;
   logic [DW-1:0]    req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic [NR-1:0]    s_sel;
   logic             s_wen;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic [NR*DW-1:0] s_rdata;
   logic [NR-1:0]    s_ack;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   checkCount;
   int   failCount;

   mem_bus_router #(
      .DW        (DW),
      .AW        (AW),
      .N_REGIONS (NR),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .s_sel     (s_sel),
      .s_wen     (s_wen),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rdata   (s_rdata),
      .s_ack     (s_ack)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Step to 1 ns after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle; optionally queue its expected response.
   task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] expRdata, input logic expErr, input bit expectRsp);
      exp_t e;
      checkOutput("req_ready_before_issue", 64'(req_ready), 64'h1);
      if (expectRsp) begin
         e.rdata = expRdata;
         e.err   = expErr;
         expQ.push_back(e);
      end
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      nextCycle();
      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   // Monitor: pop the scoreboard whenever a response handshake is about to complete.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", 64'h1, 64'h0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, monExp.rdata);
            checkOutput("rsp_err", 64'(rsp_err), 64'(monExp.err));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      s_rdata    = '0;
      s_ack      = '0;

      #12;
      $display("[TB] reset state");
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("rst_rsp_err", 64'(rsp_err), 64'h0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 64'h0);
      checkOutput("rst_s_sel", 64'(s_sel), 64'h0);
      checkOutput("rst_s_wen", 64'(s_wen), 64'h0);
      checkOutput("rst_s_addr", s_addr, 64'h0);
      checkOutput("rst_s_wdata", s_wdata, 64'h0);
      rst_n = 1'b1;
      nextCycle();
      checkOutput("rst_req_ready", 64'(req_ready), 64'h1);

      $display("[TB] test 1: zero-wait load from region 0");
      applyStimulus(1'b0, 64'h8, 64'h0, 64'hDEAD_BEEF, 1'b0, 1'b1);
      checkOutput("t1_s_sel", 64'(s_sel), 64'h1);
      checkOutput("t1_s_addr", s_addr, 64'h8);
      checkOutput("t1_s_wen", 64'(s_wen), 64'h0);
      checkOutput("t1_req_ready", 64'(req_ready), 64'h0);
      s_rdata[0 +: 64] = 64'hDEAD_BEEF;
      s_ack = 4'b0001;
      nextCycle();
      s_ack = 4'b0000;
      checkOutput("t1_rsp_valid_t2", 64'(rsp_valid), 64'h1);
      nextCycle();
      checkOutput("t1_idle_ready", 64'(req_ready), 64'h1);

      $display("[TB] test 2: store to region 1 with 3 wait cycles");
      s_rdata[64 +: 64] = 64'h1234;
      applyStimulus(1'b1, 64'h108, 64'h5, 64'h0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkOutput("t2_s_sel", 64'(s_sel), 64'h2);
         checkOutput("t2_s_wen", 64'(s_wen), 64'h1);
         checkOutput("t2_s_addr", s_addr, 64'h8);
         checkOutput("t2_s_wdata", s_wdata, 64'h5);
         checkOutput("t2_rsp_valid_low", 64'(rsp_valid), 64'h0);
         s_ack = (k == 3) ? 4'b0010 : 4'b0000;
         nextCycle();
      end
      s_ack = 4'b0000;
      checkOutput("t2_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("t2_s_sel_dropped", 64'(s_sel), 64'h0);
      nextCycle();

      $display("[TB] test 3: unmapped addresses");
      applyStimulus(1'b0, 64'hFFFF_0000, 64'h0, 64'h0, 1'b1, 1'b1);
      checkOutput("t3_s_sel", 64'(s_sel), 64'h0);
      checkOutput("t3_rsp_valid_t1", 64'(rsp_valid), 64'h1);
      nextCycle();
      applyStimulus(1'b0, 64'h120, 64'h0, 64'h0, 1'b1, 1'b1);
      checkOutput("t3b_s_sel", 64'(s_sel), 64'h0);
      checkOutput("t3b_rsp_valid_t1", 64'(rsp_valid), 64'h1);
      nextCycle();

      $display("[TB] test 4: region 2 timeout, stray and late acks");
      applyStimulus(1'b0, 64'h204, 64'h0, 64'h0, 1'b1, 1'b1);
      for (int k = 1; k <= TO; k++) begin
         checkOutput("t4_rsp_valid_low", 64'(rsp_valid), 64'h0);
         if (k == 1 || k == TO) begin
            checkOutput("t4_s_sel", 64'(s_sel), 64'h4);
            checkOutput("t4_s_addr", s_addr, 64'h4);
         end
         s_ack = (k == 2) ? 4'b0001 : 4'b0000;
         nextCycle();
      end
      s_ack = 4'b0000;
      checkOutput("t4_rsp_valid_t17", 64'(rsp_valid), 64'h1);
      checkOutput("t4_s_sel_dropped", 64'(s_sel), 64'h0);
      nextCycle();
      nextCycle();
      nextCycle();
      s_ack = 4'b0100;
      nextCycle();
      s_ack = 4'b0000;
      checkOutput("t4_late_ack_rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("t4_late_ack_req_ready", 64'(req_ready), 64'h1);

      $display("[TB] test 5: response backpressure");
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
      s_rdata[0 +: 64] = 64'h0123_4567_89AB_CDEF;
      s_ack = 4'b0001;
      nextCycle();
      s_ack = 4'b0000;
      s_rdata[0 +: 64] = 64'h0;
      for (int k = 0; k < 5; k++) begin
         checkOutput("t5_rsp_valid_held", 64'(rsp_valid), 64'h1);
         checkOutput("t5_rsp_rdata_held", rsp_rdata, 64'h0123_4567_89AB_CDEF);
         checkOutput("t5_req_ready_low", 64'(req_ready), 64'h0);
         nextCycle();
      end
      rsp_ready = 1'b1;
      nextCycle();
      checkOutput("t5_rsp_valid_released", 64'(rsp_valid), 64'h0);
      checkOutput("t5_req_ready_released", 64'(req_ready), 64'h1);

      $display("[TB] test 6: reset during access");
      applyStimulus(1'b0, 64'h100, 64'h0, 64'h0, 1'b0, 1'b0);
      checkOutput("t6_s_sel_active", 64'(s_sel), 64'h2);
      nextCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_s_sel_async_drop", 64'(s_sel), 64'h0);
      checkOutput("t6_rsp_valid_in_reset", 64'(rsp_valid), 64'h0);
      #10;
      rst_n = 1'b1;
      nextCycle();
      checkOutput("t6_req_ready_after", 64'(req_ready), 64'h1);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t6_no_stray_rsp", 64'(rsp_valid), 64'h0);
         nextCycle();
      end

      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
